alu_mem_skid_register: RTL
==========================

Name: alu_mem_skid_register

Overview:
- Parametrised successor to the execute→memory pipeline register.
- Carries ALU result, store data, destination register and write/load/store controls from EX to MEM.
- Adds a valid/ready handshake, a one-entry skid buffer (registered in_ready), a synchronous flush, and x0 write suppression.
- Sits between the ALU stage and the data-cache access stage; lets the cache stall MEM without a combinational ready path back into EX.

Parameters:
- DATA_W, 32, width of alu_result and store_data.
- REG_ADDR_W, 5, width of destination register index.
- ZERO_REG_GUARD, 1, when 1 force is_write to 0 on capture if register_d is 0.

Ports:
- clk  input  1  clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- flush  input  1  synchronous kill of all held entries.
- in_valid  input  1  EX offers an entry.
- in_ready  output  1  stage can accept; registered.
- is_write_in  input  1  entry writes register file.
- is_load_in  input  1  entry is a load.
- is_store_in  input  1  entry is a store.
- alu_result_in  input  DATA_W  ALU result / memory address.
- store_data_in  input  DATA_W  store data.
- register_d_in  input  REG_ADDR_W  destination register.
- out_valid  output  1  entry presented to MEM.
- out_ready  input  1  MEM consumes the entry.
- is_write_out  output  1  gated by out_valid.
- is_load_out  output  1  gated by out_valid.
- is_store_out  output  1  gated by out_valid.
- alu_result_out  output  DATA_W  main slot data.
- store_data_out  output  DATA_W  main slot data.
- register_d_out  output  REG_ADDR_W  main slot data.

Behaviour:
- Storage: main slot, which drives the outputs, and skid slot. Each slot holds the payload plus a valid bit.
- Events: accept = in_valid & in_ready; fire = out_valid & out_ready.
- in_ready = !skid_valid, held in a flop.
- out_valid = main_valid.
- FSM states: EMPTY (no valid slots), BUSY (main valid only), FULL (both valid).
- EMPTY:
  - accept → main<=in, go to BUSY.
  - out_ready is ignored.
- BUSY:
  - accept & fire → main<=in, stay BUSY.
  - accept & !fire → skid<=in, go to FULL, in_ready←0.
  - !accept & fire → go to EMPTY.
- FULL:
  - in_ready=0; in_valid is ignored.
  - fire → main<=skid, go to BUSY, in_ready←1.
  - !fire → hold.
- Latency: 1 cycle from accept in EMPTY, or in BUSY with fire, to out_valid.
- Throughput: 1 entry/cycle while out_ready=1.
- Ordering: strict FIFO order; the skid entry always drains before any newer entry.
- Flush:
  - Highest priority. Next state EMPTY, both valid bits cleared, in_ready←1.
  - An entry offered in the same cycle is dropped, even if in_ready=1.
  - Payload data flops are not required to clear.
- Control gating: is_write_out, is_load_out and is_store_out are forced to 0 whenever out_valid=0, so MEM never sees side effects from a bubble.
- x0 guard: with ZERO_REG_GUARD=1 and register_d_in==0, the stored is_write is 0. register_d is stored unchanged.
- Reset (reset=0, async):
  - State EMPTY, both valid bits 0, in_ready=1.
  - All payload flops and outputs 0.
  - Reset asserted mid-transfer discards all entries.
  - Release is synchronous to clk through the normal flop path; no entry is accepted on the release edge unless in_valid is high and reset is already 1 at that edge.
- Illegal state encoding recovers to EMPTY.
- No width conversion; all fields pass through unmodified except the is_write gating.

Decomposition:
- Shared package holds:
  - DATA_W and REG_ADDR_W defaults.
  - Payload struct typedef: is_write, is_load, is_store, alu_result, store_data, register_d.
  - FSM state enum: EMPTY, BUSY, FULL.
- One natural sub-module: pipe_payload_slot, a payload register with valid bit, load enable and clear, instantiated twice (main, skid).

Test Plan:
- Reset held low 3 cycles, then released → out_valid=0, in_ready=1, all outputs 0. Then in_valid=1 with alu_result_in=0x0000_1234, register_d_in=5, is_write_in=1 → next cycle out_valid=1, alu_result_out=0x1234, register_d_out=5, is_write_out=1.
- Streaming: out_ready=1, 8 back-to-back entries with alu_result 1..8 → outputs 1..8 on 8 consecutive cycles, in_ready stays 1.
- Backpressure: out_ready=0 with entries A=0xA, B=0xB offered → state FULL, in_ready=0 on the cycle after B is accepted, C held off. Raise out_ready → A, B, C emerge in order, with no loss or duplication.
- Flush in FULL, with in_valid=1 offering D the same cycle → next cycle out_valid=0, is_store_out=0, in_ready=1; D never appears.
- x0 guard: is_write_in=1, register_d_in=0, is_load_in=1 → is_write_out=0, is_load_out=1. With ZERO_REG_GUARD=0 → is_write_out=1.
- Async reset asserted mid-cycle while in FULL → outputs go to 0 immediately, without waiting for a clk edge; after release, state is EMPTY.

Source files
------------

// File: rtl/alu_mem_skid_register_pkg.sv
// Shared types and defaults for the EX->MEM skid pipeline register.
package alu_mem_skid_register_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int REG_ADDR_W_DEF = 5;

    // Payload layout at the default widths; the top rebuilds it from its own parameters.
    typedef struct packed {
        logic                      is_write;
        logic                      is_load;
        logic                      is_store;
        logic [DATA_W_DEF-1:0]     alu_result;
        logic [DATA_W_DEF-1:0]     store_data;
        logic [REG_ADDR_W_DEF-1:0] register_d;
    } pipe_payload_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    // Writes to x0 are architecturally dead, so drop the write enable at capture.
    function automatic logic guard_write(input logic is_write,
                                         input logic rd_is_zero,
                                         input logic guard_en);
        return is_write & ~(guard_en & rd_is_zero);
    endfunction

endpackage

// File: rtl/alu_mem_skid_register_slot.sv
// One payload register with a valid bit; clear wins over load and leaves the data flops untouched.
module pipe_payload_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         valid
);

    logic [W-1:0] data_r;
    logic         valid_r;

    // Payload and valid bit storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_r  <= {W{1'b0}};
            valid_r <= 1'b0;
        end else if (clear) begin
            valid_r <= 1'b0;
        end else if (load) begin
            data_r  <= d;
            valid_r <= 1'b1;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign q     = data_r;
    assign valid = valid_r;

endmodule

// File: rtl/alu_mem_skid_register.sv
// EX->MEM pipeline register with valid/ready handshake, one-entry skid buffer, flush and x0 write guard.
module alu_mem_skid_register
    import alu_mem_skid_register_pkg::*;
#(
    parameter int DATA_W         = DATA_W_DEF,
    parameter int REG_ADDR_W     = REG_ADDR_W_DEF,
    parameter int ZERO_REG_GUARD = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  is_write_in,
    input  logic                  is_load_in,
    input  logic                  is_store_in,
    input  logic [DATA_W-1:0]     alu_result_in,
    input  logic [DATA_W-1:0]     store_data_in,
    input  logic [REG_ADDR_W-1:0] register_d_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  is_write_out,
    output logic                  is_load_out,
    output logic                  is_store_out,
    output logic [DATA_W-1:0]     alu_result_out,
    output logic [DATA_W-1:0]     store_data_out,
    output logic [REG_ADDR_W-1:0] register_d_out
);

    typedef struct packed {
        logic                  is_write;
        logic                  is_load;
        logic                  is_store;
        logic [DATA_W-1:0]     alu_result;
        logic [DATA_W-1:0]     store_data;
        logic [REG_ADDR_W-1:0] register_d;
    } payload_t;

    localparam int   PAYLOAD_W = $bits(payload_t);
    localparam logic GUARD_EN  = (ZERO_REG_GUARD != 0);

    skid_state_e state_r, next_state_s;
    logic        in_ready_r;
    logic        accept_s, fire_s;
    logic        main_load_s, main_clr_s, main_from_skid_s;
    logic        skid_load_s, skid_clr_s;
    logic        main_valid_s, skid_valid_s;
    payload_t    in_payload_s, main_d_s, main_q_s, skid_q_s;

    assign accept_s = in_valid & in_ready_r;
    assign fire_s   = main_valid_s & out_ready;

    assign in_payload_s.is_write   = guard_write(is_write_in, (register_d_in == {REG_ADDR_W{1'b0}}), GUARD_EN);
    assign in_payload_s.is_load    = is_load_in;
    assign in_payload_s.is_store   = is_store_in;
    assign in_payload_s.alu_result = alu_result_in;
    assign in_payload_s.store_data = store_data_in;
    assign in_payload_s.register_d = register_d_in;

    // Next-state and slot load/clear decode; flush overrides every handshake.
    always_comb begin
        next_state_s     = state_r;
        main_load_s      = 1'b0;
        main_clr_s       = 1'b0;
        main_from_skid_s = 1'b0;
        skid_load_s      = 1'b0;
        skid_clr_s       = 1'b0;
        if (flush) begin
            next_state_s = EMPTY;
            main_clr_s   = 1'b1;
            skid_clr_s   = 1'b1;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (accept_s) begin
                        main_load_s  = 1'b1;
                        next_state_s = BUSY;
                    end else begin
                        next_state_s = EMPTY;
                    end
                end
                BUSY: begin
                    if (accept_s && fire_s) begin
                        main_load_s  = 1'b1;
                    end else if (accept_s) begin
                        skid_load_s  = 1'b1;
                        next_state_s = FULL;
                    end else if (fire_s) begin
                        main_clr_s   = 1'b1;
                        next_state_s = EMPTY;
                    end else begin
                        next_state_s = BUSY;
                    end
                end
                FULL: begin
                    if (fire_s) begin
                        main_load_s      = 1'b1;
                        main_from_skid_s = 1'b1;
                        skid_clr_s       = 1'b1;
                        next_state_s     = BUSY;
                    end else begin
                        next_state_s = FULL;
                    end
                end
                default: begin
                    next_state_s = EMPTY;
                    main_clr_s   = 1'b1;
                    skid_clr_s   = 1'b1;
                end
            endcase
        end
    end

    // State register; in_ready is precomputed so no combinational path runs from out_ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= EMPTY;
            in_ready_r <= 1'b1;
        end else begin
            state_r    <= next_state_s;
            in_ready_r <= (next_state_s != FULL);
        end
    end

    assign main_d_s = main_from_skid_s ? skid_q_s : in_payload_s;

    pipe_payload_slot #(.W(PAYLOAD_W)) u_main (
        .clk   (clk),
        .reset (reset),
        .load  (main_load_s),
        .clear (main_clr_s),
        .d     (main_d_s),
        .q     (main_q_s),
        .valid (main_valid_s)
    );

    pipe_payload_slot #(.W(PAYLOAD_W)) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load_s),
        .clear (skid_clr_s),
        .d     (in_payload_s),
        .q     (skid_q_s),
        .valid (skid_valid_s)
    );

    assign in_ready       = in_ready_r;
    assign out_valid      = main_valid_s;
    assign is_write_out   = main_valid_s & main_q_s.is_write;
    assign is_load_out    = main_valid_s & main_q_s.is_load;
    assign is_store_out   = main_valid_s & main_q_s.is_store;
    assign alu_result_out = main_q_s.alu_result;
    assign store_data_out = main_q_s.store_data;
    assign register_d_out = main_q_s.register_d;

    // The skid valid bit mirrors FULL; it is kept for symmetry with the main slot.
    logic unused_skid_valid_s;
    assign unused_skid_valid_s = skid_valid_s;

endmodule
